// File: rtl/perceptron_trainer.sv
// Training-sample sequencer for a two-input perceptron.
// Walks all four {X2,X1} samples per epoch and tallies misclassifications.
module perceptron_trainer #(
    parameter logic [3:0] TEACHER    = 4'b1101,
    parameter int         MAX_EPOCHS = 8,
    parameter int         EPOCH_W    = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               Z,
    output logic               X1,
    output logic               X2,
    output logic               S,
    output logic               SAMPLE_VALID,
    output logic               BUSY,
    output logic               DONE,
    output logic               CONVERGED,
    output logic [EPOCH_W-1:0] EPOCH,
    output logic [2:0]         ERR_CNT
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PRESENT = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_EEND    = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(MAX_EPOCHS - 1);

    logic [2:0]         state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [2:0]         run_q, run_d;
    logic [2:0]         err_q, err_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               x1_q, x1_d;
    logic               x2_q, x2_d;
    logic               s_q, s_d;
    logic               conv_q, conv_d;
    logic               load;
    logic [1:0]         nidx;

    // Next-state logic: sample stepping, error tally and epoch decision
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        run_d   = run_q;
        err_d   = err_q;
        epoch_d = epoch_q;
        conv_d  = conv_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        s_d     = s_q;
        load    = 1'b0;
        nidx    = 2'd0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d = ST_PRESENT;
                    idx_d   = 2'd0;
                    run_d   = 3'd0;
                    err_d   = 3'd0;
                    epoch_d = '0;
                    conv_d  = 1'b0;
                    load    = 1'b1;
                end
            end
            ST_PRESENT: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (Z != s_q) begin
                    run_d = run_q + 3'd1;
                end
                if (idx_q == 2'd3) begin
                    state_d = ST_EEND;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_PRESENT;
                    load    = 1'b1;
                    nidx    = idx_q + 2'd1;
                end
            end
            ST_EEND: begin
                err_d = run_q;
                run_d = 3'd0;
                idx_d = 2'd0;
                if (run_q == 3'd0) begin
                    state_d = ST_DONE;
                    conv_d  = 1'b1;
                end else if (epoch_q == LAST_EPOCH) begin
                    state_d = ST_DONE;
                    conv_d  = 1'b0;
                end else begin
                    epoch_d = epoch_q + 1'b1;
                    state_d = ST_PRESENT;
                    load    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (load) begin
            x1_d = nidx[0];
            x2_d = nidx[1];
            s_d  = TEACHER[nidx];
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            run_q   <= 3'd0;
            err_q   <= 3'd0;
            epoch_q <= '0;
            conv_q  <= 1'b0;
            x1_q    <= 1'b0;
            x2_q    <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            err_q   <= err_d;
            epoch_q <= epoch_d;
            conv_q  <= conv_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            s_q     <= s_d;
        end
    end

    assign X1           = x1_q;
    assign X2           = x2_q;
    assign S            = s_q;
    assign SAMPLE_VALID = (state_q == ST_PRESENT) || (state_q == ST_CHECK);
    assign BUSY         = SAMPLE_VALID || (state_q == ST_EEND);
    assign DONE         = (state_q == ST_DONE);
    assign CONVERGED    = conv_q;
    assign EPOCH        = epoch_q;
    assign ERR_CNT      = err_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: scenario table plus randomized Z errors,
// every cycle checked against an epoch-level reference model.
module tb_perceptron_trainer;

    typedef struct packed {
        logic       x1;
        logic       x2;
        logic       s;
        logic       sv;
        logic       busy;
        logic       done;
        logic       conv;
        logic [3:0] ep;
        logic [2:0] err;
    } obs_t;

    typedef struct {
        int mode;
        int dut;
        int glitch;
        int abort;
        bit chk;
        bit conv;
        int ep;
        int err;
        int lat;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    logic START;
    logic Z;
    logic sel;
    logic start_a, start_b;

    logic a_x1, a_x2, a_s, a_sv, a_busy, a_done, a_conv;
    logic [3:0] a_ep;
    logic [2:0] a_err;
    logic b_x1, b_x2, b_s, b_sv, b_busy, b_done, b_conv;
    logic [3:0] b_ep;
    logic [2:0] b_err;

    obs_t obs_a, obs_b, obs;

    int errors = 0;
    int checks = 0;

    logic [3:0] wr [0:15];
    obs_t exp_q[$];
    logic zq[$];

    always #5 CLK = ~CLK;

    assign start_a = START & ~sel;
    assign start_b = START & sel;

    perceptron_trainer dut_a (
        .CLK(CLK), .RST(RST), .START(start_a), .Z(Z),
        .X1(a_x1), .X2(a_x2), .S(a_s), .SAMPLE_VALID(a_sv),
        .BUSY(a_busy), .DONE(a_done), .CONVERGED(a_conv),
        .EPOCH(a_ep), .ERR_CNT(a_err)
    );

    perceptron_trainer #(
        .TEACHER(4'b0100), .MAX_EPOCHS(3), .EPOCH_W(4)
    ) dut_b (
        .CLK(CLK), .RST(RST), .START(start_b), .Z(Z),
        .X1(b_x1), .X2(b_x2), .S(b_s), .SAMPLE_VALID(b_sv),
        .BUSY(b_busy), .DONE(b_done), .CONVERGED(b_conv),
        .EPOCH(b_ep), .ERR_CNT(b_err)
    );

    assign obs_a = {a_x1, a_x2, a_s, a_sv, a_busy, a_done, a_conv, a_ep, a_err};
    assign obs_b = {b_x1, b_x2, b_s, b_sv, b_busy, b_done, b_conv, b_ep, b_err};
    assign obs   = sel ? obs_b : obs_a;

    task automatic check_obs(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b (x1 x2 s sv busy done conv ep err)",
                     name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic obs_t mk(input logic [1:0] i, input logic t, input bit sv,
                                input bit busy, input bit done, input bit conv,
                                input int e, input int er);
        obs_t o;
        o.x1   = i[0];
        o.x2   = i[1];
        o.s    = t;
        o.sv   = sv;
        o.busy = busy;
        o.done = done;
        o.conv = conv;
        o.ep   = 4'(e);
        o.err  = 3'(er);
        return o;
    endfunction

    // Expected per-cycle trace: epochs of 4 samples x 2 cycles + 1 end cycle
    task automatic build_model(input logic [3:0] t, input int m);
        int prev;
        int tot;
        logic [1:0] i2;
        exp_q.delete();
        zq.delete();
        prev = 0;
        for (int e = 0; e < m; e++) begin
            tot = 0;
            for (int i = 0; i < 4; i++) begin
                i2 = 2'(i);
                for (int c = 0; c < 2; c++) begin
                    exp_q.push_back(mk(i2, t[i], 1, 1, 0, 0, e, prev));
                    zq.push_back(t[i] ^ wr[e][i]);
                end
                tot += int'(wr[e][i]);
            end
            exp_q.push_back(mk(2'd3, t[3], 0, 1, 0, 0, e, prev));
            zq.push_back(1'b0);
            prev = tot;
            if (tot == 0 || e == m - 1) begin
                exp_q.push_back(mk(2'd3, t[3], 0, 0, 1, tot == 0, e, tot));
                zq.push_back(1'b0);
                break;
            end
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        logic [3:0] t;
        int m;
        int lat;
        sel = (v.dut != 0);
        t = sel ? 4'b0100 : 4'b1101;
        m = sel ? 3 : 8;
        for (int e = 0; e < 16; e++) begin
            case (v.mode)
                0: wr[e] = 4'h0;
                1: wr[e] = t;
                2: wr[e] = (e < 2) ? 4'hF : 4'h0;
                4: wr[e] = (e == 0) ? 4'hF : 4'h0;
                default: wr[e] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            endcase
        end
        build_model(t, m);
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        lat = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            check_obs($sformatf("%s cyc%0d", tag, k), obs, exp_q[k]);
            if (obs.done && lat < 0) lat = k + 1;
            Z = zq[k];
            START = (k == v.glitch);
            if (k == v.abort) begin
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
                START = 1'b0;
                check_obs({tag, " rst_mid"}, obs, '0);
                return;
            end
            @(negedge CLK);
            START = 1'b0;
        end
        if (v.chk) begin
            check_int({tag, " conv"}, int'(obs.conv), int'(v.conv));
            check_int({tag, " epoch"}, int'(obs.ep), v.ep);
            check_int({tag, " err_cnt"}, int'(obs.err), v.err);
            check_int({tag, " latency"}, lat, v.lat);
        end
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{0, 0, -1, -1, 1, 1, 0, 0, 10};
        tbl[1] = '{1, 0, -1, -1, 1, 0, 7, 3, 73};
        tbl[2] = '{2, 0,  3, -1, 1, 1, 2, 0, 28};
        tbl[3] = '{4, 0, -1, 14, 0, 0, 0, 0, 0};
        tbl[4] = '{0, 0, -1, -1, 1, 1, 0, 0, 10};
        tbl[5] = '{1, 1, -1, -1, 1, 0, 2, 1, 28};
        tbl[6] = '{0, 1,  5, -1, 1, 1, 0, 0, 10};

        RST = 1'b1;
        START = 1'b0;
        Z = 1'b0;
        sel = 1'b0;
        repeat (2) @(negedge CLK);
        check_obs("reset_a", obs_a, '0);
        check_obs("reset_b", obs_b, '0);
        START = 1'b1;
        @(negedge CLK);
        check_obs("rst_over_start", obs_a, '0);
        RST = 1'b0;
        START = 1'b0;

        for (int n = 0; n < 7; n++) begin
            run(tbl[n], $sformatf("vec%0d", n));
        end

        for (int n = 0; n < 10; n++) begin
            vec_t r;
            r = '{3, int'($urandom_range(0, 1)), -1, -1, 0, 0, 0, 0, 0};
            run(r, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
Training-sample sequencer that sits directly upstream of the perceptron and drives its X1, X2 and S (teacher) inputs. It steps through all four input combinations once per epoch, taking the teacher value from a parameterised truth table. It reads the perceptron's Z output to count misclassifications per epoch. Training stops on the first error-free epoch (converged) or after MAX_EPOCHS epochs (not converged).

Parameters:
TEACHER, 4'b1101, teacher truth table; S = TEACHER[{X2,X1}] (default is OR-style (!X1)|X2; 4'b0100 gives (!X1)&X2)
MAX_EPOCHS, 8, epoch limit before giving up; legal range 1..2^EPOCH_W
EPOCH_W, 4, width of the epoch counter

Ports:
CLK  input  1  clock; all state changes on the rising edge
RST  input  1  synchronous, active-high reset
START  input  1  one-cycle request to begin training; honoured only in IDLE or DONE
Z  input  1  perceptron output for the currently presented sample
X1  output  1  input bit 1 to the perceptron (registered)
X2  output  1  input bit 2 to the perceptron (registered)
S  output  1  teacher bit to the perceptron (registered)
SAMPLE_VALID  output  1  high while X1/X2/S carry a live training sample
BUSY  output  1  high from the cycle after an accepted START until DONE
DONE  output  1  high in DONE state; held until RST or a new START
CONVERGED  output  1  valid while DONE; 1 = final epoch had zero errors
EPOCH  output  EPOCH_W  index of the current epoch (final epoch while DONE)
ERR_CNT  output  3  error count of the last completed epoch (0..4)

Behaviour:
- Reset (RST=1 at a clock edge, in any state, including mid-epoch): state=IDLE. X1, X2, S, SAMPLE_VALID, BUSY, DONE and CONVERGED=0. EPOCH=0. ERR_CNT=0. Internal sample index and running error count are 0. RST has priority over START.
- States: IDLE, PRESENT, CHECK, EPOCH_END, DONE.
- IDLE/DONE + START=1 -> PRESENT. This clears EPOCH, the index, the running error count, ERR_CNT, DONE and CONVERGED.
- Entering PRESENT loads the sample for index i (0..3):
  - X1=i[0], X2=i[1], S=TEACHER[i].
  - Order per epoch is {X2,X1} = 00, 01, 10, 11.
- Each sample is held for exactly 2 cycles (PRESENT then CHECK). SAMPLE_VALID=1 in both cycles.
- CHECK: Z is sampled at the end of the cycle. If Z != S, the running error count increments.
  - i<3: i increments, next state PRESENT.
  - i=3: next state EPOCH_END.
- EPOCH_END: one cycle with SAMPLE_VALID=0.
  - ERR_CNT takes the epoch total, including the error from the CHECK cycle just completed (no lost count).
  - Running error count is 0. i=0.
  - Total=0: -> DONE, CONVERGED=1.
  - Else if EPOCH=MAX_EPOCHS-1: -> DONE, CONVERGED=0.
  - Else: EPOCH increments, -> PRESENT.
- Epoch length is 9 cycles. Total latency from START to DONE is 1 + 9*(epochs run) cycles.
- X1/X2/S hold their last values outside PRESENT/CHECK. Only SAMPLE_VALID qualifies them.
- BUSY=1 in PRESENT, CHECK and EPOCH_END. START is ignored while BUSY.
- EPOCH never wraps: the DONE check precedes the increment.

Test Plan:
1. RST, then START with Z tied to S. -> Sequence (X2,X1,S) = (0,0,1),(0,1,0),(1,0,1),(1,1,1), each held 2 cycles. DONE rises 10 cycles after START with CONVERGED=1, EPOCH=0, ERR_CNT=0.
2. Z tied to 0, default TEACHER, MAX_EPOCHS=8. -> DONE after 8 epochs (73 cycles after START) with CONVERGED=0, EPOCH=7, ERR_CNT=3.
3. Model outputs !S during epochs 0-1 and S from epoch 2. -> ERR_CNT=4 after epochs 0 and 1. Then DONE with CONVERGED=1, EPOCH=2, ERR_CNT=0.
4. Pulse START again mid-epoch. -> Ignored: sequence and EPOCH unchanged. START while DONE restarts with EPOCH=0 and DONE=0 next cycle.
5. RST asserted during CHECK of sample 2, epoch 1. -> Next cycle all outputs are at reset values. A subsequent START begins at {X2,X1}=00, epoch 0.
6. TEACHER=4'b0100, Z tied to 0. -> S sequence is 0,0,1,0. ERR_CNT=1 each epoch. CONVERGED=0 at MAX_EPOCHS.
